ltc2308_scan_ctrl: RTL and testbench
====================================

Name: ltc2308_scan_ctrl

Overview:
- Drives the on-board LTC2308CUF 8-channel 12-bit SPI ADC (adc_convst/adc_sck/adc_sdi/adc_sdo).
- Scans all channels enabled in a mask, round-robin.
- Delivers each result as a tagged sample with a one-cycle valid strobe to the soc_system register/PIO interface.
- Sits between the ADC pins and soc_system, clocked from fpga_clk1_50 and reset by hps_fpga_reset_n.

Parameters:
- CLK_DIV, 2: clk cycles per SCK half-period; default gives 12.5 MHz SCK at 50 MHz. Must be >=2.
- T_CONV, 80: clk cycles CONVST is held high for conversion; 1.6 us at 50 MHz.
- T_ACQ, 16: clk cycles of idle gap after a transfer before the next CONVST.

Ports:
- clk, input, 1: system clock (50 MHz).
- reset_n, input, 1: asynchronous active-low reset.
- enable, input, 1: level; 1 = keep scanning.
- ch_mask, input, 8: bit i = 1 means channel i is included in the scan.
- adc_convst, output, 1: ADC conversion start.
- adc_sck, output, 1: ADC serial clock.
- adc_sdi, output, 1: ADC config data, MSB first.
- adc_sdo, input, 1: ADC result data, MSB first.
- sample_data, output, 12: last result, unipolar straight binary.
- sample_ch, output, 3: channel that sample_data belongs to.
- sample_valid, output, 1: one-cycle strobe; new sample_data/sample_ch.
- busy, output, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset, asynchronous: state IDLE.
  - All outputs 0: adc_convst, adc_sck, adc_sdi, sample_data, sample_ch, sample_valid, busy.
  - Internal state cleared: prime=0, cur_ch=0, prev_ch=0.
- Config word, 6 bits, sent MSB first: {S/D=1, O/S=ch[0], S1=ch[2], S0=ch[1], UNI=1, SLP=0}.
  - ch0 maps to 100010, ch1 to 110010, ch7 to 111110.
- Pipelining: the result read in frame N is the conversion configured in frame N-1. prev_ch tracks it.
- Channel selection, evaluated when entering CONV:
  - next = lowest set bit of ch_mask strictly above cur_ch, wrapping through 0.
  - If only cur_ch is set, next = cur_ch.
  - ch_mask is sampled only at this point; mid-frame changes take effect next frame.
- FSM states and transitions:
  - IDLE: when enable=1 and ch_mask!=0, go to CONV. From IDLE, selection starts with the search base at 7, so the first pick is the lowest set bit.
  - CONV: adc_convst=1 for T_CONV cycles, then adc_convst=0 and go to XFER.
  - XFER: 12 SCK periods, each CLK_DIV cycles low then CLK_DIV cycles high. SCK idles low.
    - Bit k (k=0..11): adc_sdi is driven with config bit k at the start of the low phase; bits 6..11 drive 0.
    - adc_sdo is captured into the shift register on the clk edge where adc_sck goes 0->1.
    - After the 12th high phase, adc_sck returns to 0; go to ACQ.
  - ACQ: wait T_ACQ cycles, then:
    - if prime=1, load sample_data = shift register, sample_ch = prev_ch, and pulse sample_valid for 1 cycle;
    - set prime=1 and prev_ch=cur_ch;
    - if enable=1 and ch_mask!=0 go to CONV, else go to IDLE and clear prime.
- The first frame after leaving IDLE primes the pipeline and emits no sample.
- Frame length: T_CONV + 24*CLK_DIV + T_ACQ cycles, 144 at defaults.
- enable deasserted mid-frame: the current frame completes (ADC protocol is never truncated) and its pending sample is still emitted; then IDLE.
- Because IDLE clears prime, re-enabling always costs one priming frame.
- sample_data/sample_ch hold their value until the next valid strobe.

Test Plan:
- Reset mid-XFER (assert reset_n=0 during bit 5) -> all outputs 0 asynchronously; after release with enable=1, the first CONV comes within 1 cycle and the first sample_valid arrives only after the 2nd frame.
- ch_mask=8'h01, enable=1, ADC model returns 12'hA5C -> SDI stream 100010 every frame; from frame 2, sample_valid every 144 cycles with sample_data=A5C and sample_ch=0.
- ch_mask=8'b1010_0100 -> config order ch2,5,7,2,...; valid samples carry sample_ch 2,5,7,2 with model values matching each channel.
- SCK timing at CLK_DIV=2 -> exactly 12 rising edges per frame, 4-cycle period, adc_convst low during all of XFER, adc_convst high exactly 80 cycles.
- Drop enable during CONV of frame 3 -> frame 3 completes, one more sample_valid, then busy=0 and adc_convst stays 0; ch_mask=0 with enable=1 -> stays in IDLE.
- Change ch_mask from 01 to 80 during XFER -> the current frame's config is unaffected; the next frame configures ch7; the following valid is tagged ch0, then ch7.

Source files
------------

// File: rtl/ltc2308_scan_ctrl.sv
// Round-robin LTC2308 scanner: CONVST pulse, 12-bit SPI frame, then acquisition gap.
// Each sample strobes sample_valid one frame after it was configured; there is no backpressure.
module ltc2308_scan_ctrl #(
  parameter int CLK_DIV = 2,
  parameter int T_CONV  = 80,
  parameter int T_ACQ   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [7:0]  ch_mask,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo,
  output logic [11:0] sample_data,
  output logic [2:0]  sample_ch,
  output logic        sample_valid,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_XFER, S_ACQ} state_e;

  localparam logic [15:0] CONV_LAST = 16'(T_CONV - 1);
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] ACQ_LAST  = 16'(T_ACQ - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic        sck_q, sck_d;
  logic        sdi_q, sdi_d;
  logic [11:0] shift_q, shift_d;
  logic [2:0]  cur_ch_q, cur_ch_d;
  logic [2:0]  prev_ch_q, prev_ch_d;
  logic        prime_q, prime_d;
  logic [11:0] data_q, data_d;
  logic [2:0]  ch_q, ch_d;
  logic        valid_q, valid_d;

  logic [2:0]  base, cand, next_ch;
  logic        found;
  logic        start_ok;
  logic [5:0]  cfg, cfg_shl;
  logic [3:0]  bit_nxt;

  // Search upward from the base, wrapping; i=8 lands back on the base itself.
  always_comb begin
    base    = (state_q == S_IDLE) ? 3'd7 : cur_ch_q;
    next_ch = base;
    cand    = '0;
    found   = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cand = base + 3'(i);
      if (!found && ch_mask[cand]) begin
        next_ch = cand;
        found   = 1'b1;
      end
    end
  end

  assign start_ok = enable && (ch_mask != 8'h00);
  assign cfg      = {1'b1, cur_ch_q[0], cur_ch_q[2], cur_ch_q[1], 1'b1, 1'b0};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sck_d     = sck_q;
    sdi_d     = sdi_q;
    shift_d   = shift_q;
    cur_ch_d  = cur_ch_q;
    prev_ch_d = prev_ch_q;
    prime_d   = prime_q;
    data_d    = data_q;
    ch_d      = ch_q;
    valid_d   = 1'b0;
    bit_nxt   = bit_q + 4'd1;
    cfg_shl   = cfg << bit_nxt;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d  = S_CONV;
          cnt_d    = '0;
          cur_ch_d = next_ch;
        end
      end
      S_CONV: begin
        if (cnt_q == CONV_LAST) begin
          state_d = S_XFER;
          cnt_d   = '0;
          bit_d   = '0;
          sdi_d   = cfg[5];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_XFER: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sck_q) begin
            sck_d   = 1'b1;
            shift_d = {shift_q[10:0], adc_sdo};
          end else begin
            sck_d = 1'b0;
            if (bit_q == 4'd11) begin
              state_d = S_ACQ;
              sdi_d   = 1'b0;
            end else begin
              bit_d = bit_nxt;
              sdi_d = cfg_shl[5];
            end
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ACQ: begin
        if (cnt_q == ACQ_LAST) begin
          cnt_d = '0;
          if (prime_q) begin
            data_d  = shift_q;
            ch_d    = prev_ch_q;
            valid_d = 1'b1;
          end
          prev_ch_d = cur_ch_q;
          if (start_ok) begin
            state_d  = S_CONV;
            prime_d  = 1'b1;
            cur_ch_d = next_ch;
          end else begin
            state_d = S_IDLE;
            prime_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sck_q     <= 1'b0;
      sdi_q     <= 1'b0;
      shift_q   <= '0;
      cur_ch_q  <= '0;
      prev_ch_q <= '0;
      prime_q   <= 1'b0;
      data_q    <= '0;
      ch_q      <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sck_q     <= sck_d;
      sdi_q     <= sdi_d;
      shift_q   <= shift_d;
      cur_ch_q  <= cur_ch_d;
      prev_ch_q <= prev_ch_d;
      prime_q   <= prime_d;
      data_q    <= data_d;
      ch_q      <= ch_d;
      valid_q   <= valid_d;
    end
  end

  assign adc_convst   = (state_q == S_CONV);
  assign busy         = (state_q != S_IDLE);
  assign adc_sck      = sck_q;
  assign adc_sdi      = sdi_q;
  assign sample_data  = data_q;
  assign sample_ch    = ch_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_ltc2308_scan_ctrl.sv
// Directed bench for ltc2308_scan_ctrl with a behavioural LTC2308 model and per-frame timing monitor.
module tb_ltc2308_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  ch_mask = 8'h00;
  logic        adc_sdo;
  logic        adc_convst, adc_sck, adc_sdi, sample_valid, busy;
  logic [11:0] sample_data;
  logic [2:0]  sample_ch;

  always #5 clk = ~clk;

  ltc2308_scan_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .ch_mask      (ch_mask),
    .adc_convst   (adc_convst),
    .adc_sck      (adc_sck),
    .adc_sdi      (adc_sdi),
    .adc_sdo      (adc_sdo),
    .sample_data  (sample_data),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  int total = 0;
  int bad   = 0;

  logic [11:0] adc_val [8] = '{12'hA5C, 12'h3C1, 12'h7E2, 12'h111,
                               12'h0F0, 12'h5A5, 12'h9C3, 12'hFFF};

  // ADC model: config latched from SDI on SCK rise, result shifted out on SCK fall.
  logic [11:0] sdo_word  = '0;
  logic [5:0]  cfg_sr    = '0;
  logic [5:0]  frame_cfg = '0;
  logic [2:0]  conv_ch   = '0;
  logic        cv_prev   = 1'b0;
  logic        sck_prev  = 1'b0;
  int          sdi_bits  = 0;
  int          tail_bad  = 0;

  assign adc_sdo = sdo_word[11];

  always @(adc_convst or adc_sck) begin
    if (adc_convst !== cv_prev) begin
      if (adc_convst) begin
        conv_ch  = {frame_cfg[3], frame_cfg[2], frame_cfg[4]};
        sdi_bits = 0;
      end else begin
        sdo_word = adc_val[conv_ch];
      end
      cv_prev = adc_convst;
    end
    if (adc_sck !== sck_prev) begin
      if (adc_sck) begin
        if (sdi_bits < 6) begin
          cfg_sr = {cfg_sr[4:0], adc_sdi};
          if (sdi_bits == 5) frame_cfg = cfg_sr;
        end else if (adc_sdi) begin
          tail_bad++;
        end
        sdi_bits++;
      end else begin
        sdo_word = {sdo_word[10:0], 1'b0};
      end
      sck_prev = adc_sck;
    end
  end

  // Frame monitor; statistics of the finished frame are latched when CONVST rises.
  int   conv_len = 0, rises = 0, since = 0, bad_per = 0, ovl = 0;
  int   l_conv = 0, l_rise = 0, l_bad_per = 0, l_ovl = 0;
  logic m_cv = 1'b0, m_sck = 1'b0;

  always @(negedge clk) begin
    if (adc_convst && !m_cv) begin
      l_conv = conv_len; l_rise = rises; l_bad_per = bad_per; l_ovl = ovl;
      conv_len = 0; rises = 0; bad_per = 0; ovl = 0; since = 0;
    end
    if (adc_convst) conv_len++;
    if (adc_convst && adc_sck) ovl = 1;
    since++;
    if (adc_sck && !m_sck) begin
      rises++;
      if (rises > 1 && since != 4) bad_per = 1;
      since = 0;
    end
    m_cv  = adc_convst;
    m_sck = adc_sck;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int bound, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!sample_valid && cnt < bound);
    #1;
    total++;
    if (!sample_valid) begin
      bad++;
      $display("FAIL valid_timeout: no sample_valid within %0d cycles", bound);
    end
  endtask

  task automatic check_frame(input string tag, input int exp_cfg);
    chk({tag, "_cfg"},    int'(frame_cfg), exp_cfg);
    chk({tag, "_convst"}, l_conv, 80);
    chk({tag, "_rises"},  l_rise, 12);
    chk({tag, "_sckper"}, l_bad_per, 0);
    chk({tag, "_ovl"},    l_ovl, 0);
  endtask

  typedef struct {
    logic [7:0] mask;
    int         mode;     // 0 keep mask, 1 change at frame start, 2 change mid-XFER
    logic [5:0] exp_cfg;  // SDI word sent in this frame
    logic [2:0] exp_ch;   // tag of the sample strobed at the end of this frame
  } vec_t;

  vec_t tbl [10];
  int   n, wt, viol;

  initial begin
    tbl[0] = '{8'h00, 0, 6'b100010, 3'd0};
    tbl[1] = '{8'h80, 2, 6'b100010, 3'd0};
    tbl[2] = '{8'h00, 0, 6'b111110, 3'd0};
    tbl[3] = '{8'h00, 0, 6'b111110, 3'd7};
    tbl[4] = '{8'hA4, 1, 6'b111110, 3'd7};
    tbl[5] = '{8'h00, 0, 6'b100110, 3'd7};
    tbl[6] = '{8'h00, 0, 6'b111010, 3'd2};
    tbl[7] = '{8'h00, 0, 6'b111110, 3'd5};
    tbl[8] = '{8'h00, 0, 6'b100110, 3'd7};
    tbl[9] = '{8'h00, 0, 6'b111010, 3'd2};

    #2 reset_n = 1'b0;
    #1;
    chk("rst_convst", int'(adc_convst), 0);
    chk("rst_sck",    int'(adc_sck), 0);
    chk("rst_sdi",    int'(adc_sdi), 0);
    chk("rst_data",   int'(sample_data), 0);
    chk("rst_ch",     int'(sample_ch), 0);
    chk("rst_valid",  int'(sample_valid), 0);
    chk("rst_busy",   int'(busy), 0);

    @(negedge clk);
    enable = 1'b1; ch_mask = 8'h01; reset_n = 1'b1;
    @(negedge clk);
    chk("first_conv", int'(adc_convst), 1);
    chk("first_busy", int'(busy), 1);

    // Land in the high phase of SDI bit 5, then reset asynchronously.
    repeat (102) @(negedge clk);
    chk("bit5_sck_high", int'(adc_sck), 1);
    reset_n = 1'b0;
    #1;
    chk("arst_convst", int'(adc_convst), 0);
    chk("arst_sck",    int'(adc_sck), 0);
    chk("arst_sdi",    int'(adc_sdi), 0);
    chk("arst_busy",   int'(busy), 0);
    chk("arst_valid",  int'(sample_valid), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("conv_after_rst", int'(adc_convst), 1);
    wait_valid(600, n);
    chk("prime_latency", n + 1, 289);
    chk("prime_ch",   int'(sample_ch), 0);
    chk("prime_data", int'(sample_data), 'hA5C);
    check_frame("prime", 'b100010);

    for (int i = 0; i < 10; i++) begin
      wt = 0;
      if (tbl[i].mode == 1) ch_mask = tbl[i].mask;
      if (tbl[i].mode == 2) begin
        repeat (90) @(negedge clk);
        ch_mask = tbl[i].mask;
        wt = 90;
      end
      wait_valid(400, n);
      chk($sformatf("vec%0d_period", i), wt + n, 144);
      chk($sformatf("vec%0d_ch", i),   int'(sample_ch), int'(tbl[i].exp_ch));
      chk($sformatf("vec%0d_data", i), int'(sample_data), int'(adc_val[tbl[i].exp_ch]));
      check_frame($sformatf("vec%0d", i), int'(tbl[i].exp_cfg));
    end

    // Drop enable during CONV: frame finishes, last sample still delivered.
    enable = 1'b0;
    wait_valid(400, n);
    chk("drop_period", n, 144);
    chk("drop_ch",     int'(sample_ch), 5);
    chk("drop_data",   int'(sample_data), 'h5A5);
    chk("drop_busy",   int'(busy), 0);
    chk("drop_convst", int'(adc_convst), 0);
    viol = 0;
    repeat (300) begin
      @(negedge clk);
      if (busy || adc_convst || adc_sck || sample_valid) viol++;
    end
    chk("idle_quiet", viol, 0);
    chk("idle_hold_data", int'(sample_data), 'h5A5);

    enable = 1'b1; ch_mask = 8'h00;
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy || adc_convst) viol++;
    end
    chk("mask0_idle", viol, 0);

    ch_mask = 8'h01;
    wait_valid(600, n);
    chk("reenable_latency", n, 289);
    chk("reenable_ch",   int'(sample_ch), 0);
    chk("reenable_data", int'(sample_data), 'hA5C);
    chk("sdi_tail_zero", tail_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
